nibble_serial_addsub: RTL and testbench



---
 rtl/nibble_serial_addsub_pkg.sv | 19 +
 rtl/nibble_serial_addsub_nibble_addc.sv | 35 +++
 rtl/nibble_serial_addsub.sv | 112 +++++++++++
 tb/tb_nibble_serial_addsub.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// ============================================================================
// Module : nibble_serial_addsub_pkg
// Shared state encoding and mode constants for the nibble-serial add/sub.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_serial_addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/nibble_serial_addsub_nibble_addc.sv
// ============================================================================
// Module : nibble_addc
// Combinational 4-bit add/subtract slice with carry-in, carry-out and c3.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_addc
    import nibble_serial_addsub_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       mode,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    logic [3:0] b_eff;
    logic [4:0] full;
    logic [3:0] low;

    // Subtraction is a + ~b with the initial carry supplied by the sequencer.
    assign b_eff = (mode == MODE_ADD) ? b : ~b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    assign low   = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};

    assign sum  = full[3:0];
    assign cout = full[4];
    assign c3   = low[3];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
// ============================================================================
// Module : nibble_serial_addsub
// Multi-nibble add/subtract, one nibble per clock, LSB first, with handshakes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          mode_q;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [3:0]    nib_sum;
    logic          nib_cout;
    logic          nib_c3;

    // Single shared slice; the current nibble is steered in by shifting.
    assign a_sh = a_q >> {idx, 2'b00};
    assign b_sh = b_q >> {idx, 2'b00};

    nibble_addc u_addc (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .mode (mode_q),
        .sum  (nib_sum),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                        idx    <= '0;
                        carry  <= (mode == MODE_SUB);
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IW'(n)) begin
                            result[4*n +: 4] <= nib_sum;
                        end
                    end
                    carry <= nib_cout;
                    if (idx == LAST_IDX) begin
                        // Top-slice c3 is the carry into bit W-1.
                        cout  <= nib_cout;
                        ovf   <= nib_c3 ^ nib_cout;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
// ============================================================================
// Module : tb_nibble_serial_addsub
// Randomised and directed bench with a behavioural arithmetic/timing model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_addsub;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    nibble_serial_addsub #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 computing, 2 holding a result.
    int           m_phase = 0;
    int           m_idx   = 0;
    logic [W-1:0] m_res   = '0;
    logic [W-1:0] m_fin   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         m_fc    = 1'b0;
    logic         m_fo    = 1'b0;
    int           sa, sb, sr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_idx   = 0;
            m_res   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    sa = int'($signed(a));
                    sb = int'($signed(b));
                    if (mode) begin
                        m_fin = a - b;
                        m_fc  = (a >= b);
                        sr    = sa - sb;
                    end else begin
                        m_fin = a + b;
                        m_fc  = ((int'(a) + int'(b)) > 65535);
                        sr    = sa + sb;
                    end
                    m_fo    = (sr > 32767) || (sr < -32768);
                    m_idx   = 0;
                    m_phase = 1;
                end
                1: begin
                    m_res[4*m_idx +: 4] = m_fin[4*m_idx +: 4];
                    m_idx++;
                    if (m_idx == N) begin
                        m_cout  = m_fc;
                        m_ovf   = m_fo;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready",  in_ready,  m_phase == 0);
        check("out_valid", out_valid, m_phase == 2);
        check("result",    result,    m_res);
        check("cout",      cout,      m_cout);
        check("ovf",       ovf,       m_ovf);
    end

    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm);
        logic acc;
        int   guard;
        a = ta; b = tb_v; mode = tm; in_valid = 1'b1;
        acc = 1'b0; guard = 0;
        while (!acc) begin
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (!acc && guard > 100) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready stayed low, required 1");
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL valid_timeout: out_valid stayed low, required 1");
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                          input int hold, output logic [W-1:0] r, output logic c,
                          output logic o, output int lat);
        out_ready = (hold == 0);
        accept(ta, tb_v, tm);
        wait_valid(lat);
        r = result; c = cout; o = ovf;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [W-1:0] r, r0;
    logic         c, o;
    int           lat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {cout, ovf}, 0);

        run_op(16'h1234, 16'h0FCD, 1'b0, 0, r, c, o, lat);
        check("add_latency", lat, N);
        check("add_result", r, 16'h2201);
        check("add_flags", {c, o}, 2'b00);

        run_op(16'h0005, 16'h0007, 1'b1, 1, r, c, o, lat);
        check("sub_borrow_result", r, 16'hFFFE);
        check("sub_borrow_flags", {c, o}, 2'b00);

        run_op(16'h7FFF, 16'h0001, 1'b0, 0, r, c, o, lat);
        check("add_ovf_result", r, 16'h8000);
        check("add_ovf_flags", {c, o}, 2'b01);

        run_op(16'h8000, 16'h0001, 1'b1, 2, r, c, o, lat);
        check("sub_ovf_result", r, 16'h7FFF);
        check("sub_ovf_flags", {c, o}, 2'b11);

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, r, c, o, lat);
        check("wrap_result", r, 16'h0000);
        check("wrap_flags", {c, o}, 2'b10);

        // Backpressure with a competing offer held on the input side.
        out_ready = 1'b0;
        accept(16'h1111, 16'h2222, 1'b0);
        wait_valid(lat);
        r0 = result;
        check("bp_first_result", r0, 16'h3333);
        a = 16'h0101; b = 16'h0202; mode = 1'b0; in_valid = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
            check("bp_hold_result", result, r0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        @(posedge clk); #1;
        check("bp_pending_taken", in_ready, 0);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_pending_result", result, 16'h0303);
        @(posedge clk); #1;

        // Reset two clocks into an operation.
        accept(16'h9ABC, 16'h1357, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_flags", {cout, ovf, out_valid}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), r, c, o, lat);
            check("rand_latency", lat, N);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
